multiplicador_algoritmico: RTL and testbench

- Sequential signed shift-and-add multiplier: the inverse operation of the team's sequential signed divider, with the same Start/Done operand handshake.
- Accepts two signed tamanyo-bit operands and returns the signed 2*tamanyo-bit product after a fixed latency.
- Sits beside the divider in the arithmetic unit. Also serves as the reference multiplier for divider self-checks (Coc*Den+Res == Num).

---
 rtl/mult_pkg.sv | 17 +
 rtl/multiplicador_algoritmico_complemento_a2.sv | 13 +
 rtl/multiplicador_algoritmico.sv | 127 ++++++++++++
 tb/tb_multiplicador_algoritmico.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential signed multiplier: FSM state encoding and the
// width of the ADD/SHIFT iteration counter.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } e_state;

  // Counter must hold tamanyo-1, so $clog2(tamanyo) bits are enough.
  function automatic int cont_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiplicador_algoritmico_complemento_a2.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
// Shared between the multiplier and the divider.
module complemento_a2 #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/multiplicador_algoritmico.sv
// Sequential signed shift-and-add multiplier with a Start/Done handshake.
// Magnitudes are multiplied unsigned; the sign is applied when the result is stored.
module multiplicador_algoritmico
  import mult_pkg::*;
#(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     A,
  input  logic [tamanyo-1:0]     B,
  output logic [2*tamanyo-1:0]   Producto,
  output logic                   Busy,
  output logic                   Done
);

  localparam int CW = cont_width(tamanyo);

  e_state               state;
  logic                 sign_a;
  logic                 sign_b;
  logic [tamanyo-1:0]   m;
  logic [tamanyo-1:0]   q;
  logic [tamanyo:0]     acc;
  logic [CW-1:0]        cont;

  logic [tamanyo-1:0]   abs_a;
  logic [tamanyo-1:0]   abs_b;
  logic [2*tamanyo-1:0] mag_next;
  logic [2*tamanyo-1:0] prod_signed;

  complemento_a2 #(.W(tamanyo)) u_abs_a (
    .neg  (A[tamanyo-1]),
    .din  (A),
    .dout (abs_a)
  );

  complemento_a2 #(.W(tamanyo)) u_abs_b (
    .neg  (B[tamanyo-1]),
    .din  (B),
    .dout (abs_b)
  );

  // Product magnitude as it will look after the final shift, so Producto and
  // Done can be registered on the same edge that enters FIN.
  assign mag_next = {acc, q[tamanyo-1:1]};

  complemento_a2 #(.W(2*tamanyo)) u_sign_fix (
    .neg  (sign_a ^ sign_b),
    .din  (mag_next),
    .dout (prod_signed)
  );

  // NOTE: every register, datapath included, is reset so no partial result
  // from an aborted operation can leak out after RSTa.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state    <= IDLE;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      m        <= '0;
      q        <= '0;
      acc      <= '0;
      cont     <= '0;
      Producto <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below is
      // overridden later in the same block when FIN is entered.
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            sign_a <= A[tamanyo-1];
            sign_b <= B[tamanyo-1];
            m      <= abs_a;
            q      <= abs_b;
            acc    <= '0;
            cont   <= CW'(tamanyo - 1);
            state  <= ADD;
            Busy   <= 1'b1;
          end
        end
        ADD: begin
          if (q[0]) begin
            acc <= acc + {1'b0, m};
          end
          state <= SHIFT;
        end
        SHIFT: begin
          {acc, q} <= {1'b0, acc, q[tamanyo-1:1]};
          if (cont == '0) begin
            Producto <= prod_signed;
            Done     <= 1'b1;
            state    <= FIN;
          end else begin
            cont  <= cont - CW'(1);
            state <= ADD;
          end
        end
        FIN: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  a_start_to_add: assert property (@(posedge CLK) disable iff (!RSTa)
    (state == IDLE && Start) |=> (state == ADD));

  a_done_in_fin: assert property (@(posedge CLK) disable iff (!RSTa)
    Done |-> (state == FIN));

  a_done_single: assert property (@(posedge CLK) disable iff (!RSTa)
    Done |=> !Done);

  a_busy_state: assert property (@(posedge CLK) disable iff (!RSTa)
    Busy == (state != IDLE));

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// Self-checking bench: directed corner cases, handshake/reset scenarios and
// random operands checked against a plain-arithmetic signed product model.
module tb_multiplicador_algoritmico;

  localparam int W   = 32;
  localparam int LAT = 2 * W + 1;

  logic           CLK   = 1'b0;
  logic           RSTa  = 1'b0;
  logic           Start = 1'b0;
  logic [W-1:0]   A     = '0;
  logic [W-1:0]   B     = '0;
  logic [2*W-1:0] Producto;
  logic           Busy;
  logic           Done;

  int             n_cmp = 0;
  int             n_bad = 0;
  logic [2*W-1:0] last_exp = '0;

  always #5 CLK = ~CLK;

  multiplicador_algoritmico #(.tamanyo(W)) dut (
    .CLK      (CLK),
    .RSTa     (RSTa),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Producto (Producto),
    .Busy     (Busy),
    .Done     (Done)
  );

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents operands for edge 0, then scrambles them to prove they are latched.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    check("hold_on_start", Producto, last_exp);
  endtask

  // Cycle c ends at edge c; returns the cycle in which Done is first seen.
  task automatic wait_done(input int inject_at, output int lat);
    int busy_low;
    busy_low = 0;
    lat = 0;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(negedge CLK);
      if (c == inject_at) begin
        A = 9;
        B = 9;
        Start = 1'b1;
      end else if (c == inject_at + 1) begin
        Start = 1'b0;
      end
      if (!Busy) busy_low++;
      if (Done) begin
        lat = c;
        break;
      end
    end
    check("busy_during", 64'(busy_low), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int inject_at, input string tag);
    int lat;
    start_op(a, b);
    wait_done(inject_at, lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check(tag, Producto, exp);
    last_exp = exp;
    @(negedge CLK);
    check("done_pulse", {63'd0, Done}, 64'd0);
    check("busy_idle", {63'd0, Busy}, 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    int idle_cnt;
    int t[4];
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #12;
    check("rst_prod", Producto, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    @(negedge CLK);
    RSTa = 1'b1;

    run_op(32'd7, 32'd6, 64'd42, -5, "p7x6");
    run_op(-32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, -5, "m7x6");
    run_op(-32'sd7, -32'sd6, 64'd42, -5, "m7xm6");
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -5, "min_x_min");
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, -5, "min_x_max");

    // Start held high: one run per IDLE visit, one IDLE cycle between runs.
    pulses = 0;
    idle_cnt = 0;
    for (int i = 0; i < 4; i++) t[i] = -1;
    @(negedge CLK);
    A = '0;
    B = '1;
    Start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge CLK);
      if (!Busy) idle_cnt++;
      if (Done) begin
        if (pulses < 4) t[pulses] = c;
        pulses++;
        check("held_prod", Producto, 64'd0);
      end
    end
    Start = 1'b0;
    check("held_count", 64'(pulses), 64'd3);
    check("held_t0", 64'(t[0]), 64'd65);
    check("held_t1", 64'(t[1]), 64'd131);
    check("held_t2", 64'(t[2]), 64'd197);
    check("held_idle", 64'(idle_cnt), 64'd3);
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge CLK);
      if (!Busy && !Done) break;
    end
    check("held_drain_busy", {63'd0, Busy}, 64'd0);
    last_exp = '0;

    run_op(32'd5, 32'd3, 64'd15, 10, "ignore_start");

    // Asynchronous reset in the middle of an operation.
    start_op(32'd100, 32'd100);
    repeat (20) @(posedge CLK);
    #2;
    RSTa = 1'b0;
    #1;
    check("midrst_prod", Producto, 64'd0);
    check("midrst_done", {63'd0, Done}, 64'd0);
    check("midrst_busy", {63'd0, Busy}, 64'd0);
    @(negedge CLK);
    RSTa = 1'b1;
    last_exp = '0;
    run_op(-32'sd3, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, -5, "after_rst");

    for (int n = 0; n < 40; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      run_op(ra, rb, ref_product(ra, rb), -5, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
